hazard_stall_ctrl: RTL

//  Pipeline hazard controller for the 5-stage core (IF/ID/EX/MEM/WB).

---
 rtl/hazard_stall_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// Purpose: ID-stage hazard detection for the 5-stage core (Tuse/Tnew data hazards plus mult/div busy tracking).
// Latency: stall/clr_EX/mdBusy are combinational (0 cycles); md busy counter and stall counter update on each rising edge.
// Backpressure: stall freezes PC and IF/ID while clr_EX injects a bubble into ID/EX in the same cycle.
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_ID,
  input  logic [4:0]  rt_ID,
  input  logic [1:0]  tuseRs_ID,
  input  logic [1:0]  tuseRt_ID,
  input  logic [4:0]  regaddr_EX,
  input  logic [1:0]  tnew_EX,
  input  logic [4:0]  regaddr_MEM,
  input  logic [1:0]  tnew_MEM,
  input  logic        mdStart_EX,
  input  logic        mdIsDiv_EX,
  input  logic        mdUse_ID,
  output logic        stall,
  output logic        clr_EX,
  output logic        mdBusy,
  output logic [31:0] stallCnt
);

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [31:0]      CNT_MAX   = 32'hFFFF_FFFF;

  md_state_e        md_state_q, md_state_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;

  logic haz_rs, haz_rt, md_haz, busy_raw, stall_raw;

  // A source register conflicts when a younger-stage producer writes it and
  // its result arrives later than the ID instruction needs it. $0 is never a
  // real dependency; tuse=3 can never be exceeded since tnew tops out at 2.
  function automatic logic src_haz(
    input logic [4:0] r,
    input logic [1:0] tuse,
    input logic [4:0] ex_dst,
    input logic [1:0] ex_tnew,
    input logic [4:0] mem_dst,
    input logic [1:0] mem_tnew
  );
    logic haz_e, haz_m;
    haz_e = (ex_dst == r) && (ex_tnew > tuse);
    haz_m = (mem_dst == r) && (mem_tnew > tuse);
    return (r != 5'd0) && (haz_e || haz_m);
  endfunction

  // Hazard decode: data hazards on either source, plus any md-unit user while busy.
  always_comb begin
    haz_rs    = src_haz(rs_ID, tuseRs_ID, regaddr_EX, tnew_EX, regaddr_MEM, tnew_MEM);
    haz_rt    = src_haz(rt_ID, tuseRt_ID, regaddr_EX, tnew_EX, regaddr_MEM, tnew_MEM);
    // A start in EX counts as busy this very cycle so a back-to-back md user waits.
    busy_raw  = (md_cnt_q != '0) || mdStart_EX;
    md_haz    = mdUse_ID && busy_raw;
    stall_raw = haz_rs || haz_rt || md_haz;
  end

  // Outputs are held low while reset is asserted, independent of inputs.
  always_comb begin
    mdBusy   = busy_raw && !reset;
    stall    = stall_raw && !reset;
    clr_EX   = stall;
    stallCnt = stall_cnt_q;
  end

  // Next state for the md busy counter: a start (re)loads, otherwise count down to zero.
  always_comb begin
    md_cnt_d   = md_cnt_q;
    md_state_d = md_state_q;
    if (mdStart_EX) begin
      md_cnt_d   = mdIsDiv_EX ? DIV_LOAD : MULT_LOAD;
      md_state_d = MD_BUSY;
    end else if (md_state_q == MD_BUSY) begin
      md_cnt_d   = md_cnt_q - CNT_W'(1);
      md_state_d = (md_cnt_q == CNT_W'(1)) ? MD_IDLE : MD_BUSY;
    end
  end

  // Next value for the saturating stall-cycle counter.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // State registers; async reset clears the md counter and stall count immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_state_q  <= MD_IDLE;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      md_state_q  <= md_state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
